// File: rtl/nios2_system_cpu_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI debug-RAM arbiter.
package nios2_system_cpu_ocimem_pkg;

    localparam int unsigned JDO_W          = 38;
    localparam int unsigned JDO_ADDR_LSB   = 18;
    localparam int unsigned JDO_RD_BIT     = 35;
    localparam int unsigned JDO_CLRERR_BIT = 36;
    localparam int unsigned JDO_WDATA_LSB  = 3;
    localparam int unsigned JDO_WDATA_W    = 32;
    localparam int unsigned BE_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        J_RD = 2'd1,
        C_RD = 2'd2
    } ocimem_state_t;

    typedef enum logic {
        JOP_RD = 1'b0,
        JOP_WR = 1'b1
    } jop_t;

    // Payload of the one-entry JTAG pending register.
    typedef struct packed {
        jop_t                   op;
        logic [JDO_WDATA_W-1:0] data;
    } jcmd_t;

endpackage

// File: rtl/nios2_system_cpu_ocimem_jcmd.sv
// JTAG command decode: pending register, jaddr, MonDReg and ready/error flags.
module nios2_system_cpu_ocimem_jcmd
    import nios2_system_cpu_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              j_grant,
    input  logic              j_rd_done,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              jpend,
    output jcmd_t             jcmd,
    output logic [ADDR_W-1:0] jaddr,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    logic rd_req;
    logic new_cmd;
    logic wr_done;
    logic complete;
    logic busy;
    logic accept;
    logic drop;
    jop_t new_op;

    // A write granted this cycle frees the pending slot in time for a new pulse.
    always_comb begin
        rd_req   = take_no_action_ocimem_a | (take_action_ocimem_a & jdo[JDO_RD_BIT]);
        new_cmd  = rd_req | take_action_ocimem_b;
        new_op   = take_action_ocimem_b ? JOP_WR : JOP_RD;
        wr_done  = j_grant & (jcmd.op == JOP_WR);
        complete = wr_done | j_rd_done;
        busy     = jpend & ~wr_done;
        accept   = new_cmd & ~busy;
        drop     = new_cmd & busy;
    end

    // Later assignments win: an address load beats the post-access increment,
    // a new accept clears ready, and a drop beats an error clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            jpend         <= 1'b0;
            jcmd          <= '0;
            jaddr         <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            if (complete) begin
                jpend         <= 1'b0;
                jaddr         <= jaddr + ADDR_W'(1);
                monitor_ready <= 1'b1;
            end
            if (j_rd_done) begin
                MonDReg <= ram_rdata;
            end
            if (take_action_ocimem_a) begin
                jaddr <= jdo[JDO_ADDR_LSB +: ADDR_W];
            end
            if (accept) begin
                jpend         <= 1'b1;
                jcmd.op       <= new_op;
                jcmd.data     <= jdo[JDO_WDATA_LSB +: JDO_WDATA_W];
                monitor_ready <= 1'b0;
            end
            if (take_action_ocimem_a & jdo[JDO_CLRERR_BIT]) begin
                monitor_error <= 1'b0;
            end
            if (drop) begin
                monitor_error <= 1'b1;
            end
        end
    end

    logic unused_jdo;
    assign unused_jdo = ^{jdo[JDO_W-1], jdo[JDO_WDATA_LSB-1:0]};

endmodule

// File: rtl/nios2_system_cpu_ocimem_arbiter.sv
// Arbitrates the single-port OCI debug RAM between JTAG commands and the CPU slave.
// Define OCIMEM_ROUND_ROBIN_EN for round-robin under contention; default is JTAG priority.
module nios2_system_cpu_ocimem_arbiter
    import nios2_system_cpu_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [BE_W-1:0]   avs_byteenable,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [BE_W-1:0]   ram_be,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata
);

    ocimem_state_t     state;
    ocimem_state_t     state_next;
    logic              jpend;
    jcmd_t             jcmd;
    logic [ADDR_W-1:0] jaddr;
    logic              cpu_req;
    logic              j_prio;
    logic              j_win;
    logic              c_win;
    logic              cpu_done;
    logic              j_rd_done;

`ifdef OCIMEM_ROUND_ROBIN_EN
    logic last_grant;  // 1: the CPU holds the most recent grant

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b0;
        end else if (j_win) begin
            last_grant <= 1'b0;
        end else if (c_win) begin
            last_grant <= 1'b1;
        end
    end

    assign j_prio = last_grant;
`else
    assign j_prio = 1'b1;
`endif

    assign cpu_req   = avs_read | avs_write;
    assign j_rd_done = (state == J_RD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant and RAM strobes are issued in the same IDLE cycle; RAM registers them.
    always_comb begin
        state_next   = state;
        j_win        = 1'b0;
        c_win        = 1'b0;
        cpu_done     = 1'b0;
        avs_readdata = '0;
        ram_addr     = '0;
        ram_wdata    = '0;
        ram_be       = '0;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    j_win = jpend & (~cpu_req | j_prio);
                    c_win = cpu_req & ~j_win;
                    if (j_win) begin
                        ram_addr  = jaddr;
                        ram_wdata = DATA_W'(jcmd.data);
                        ram_be    = '1;
                        ram_we    = (jcmd.op == JOP_WR);
                        ram_re    = (jcmd.op == JOP_RD);
                        if (jcmd.op == JOP_RD) begin
                            state_next = J_RD;
                        end
                    end else if (c_win) begin
                        ram_addr  = avs_address;
                        ram_wdata = avs_writedata;
                        ram_be    = avs_byteenable;
                        ram_re    = avs_read;
                        ram_we    = ~avs_read;
                        if (avs_read) begin
                            state_next = C_RD;
                        end else begin
                            cpu_done = 1'b1;
                        end
                    end
                end
                J_RD: begin
                    state_next = IDLE;
                end
                C_RD: begin
                    cpu_done     = 1'b1;
                    avs_readdata = ram_rdata;
                    state_next   = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
        avs_waitrequest = cpu_req & ~cpu_done;
    end

    nios2_system_cpu_ocimem_jcmd #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_jcmd (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .j_grant                 (j_win),
        .j_rd_done               (j_rd_done),
        .ram_rdata               (ram_rdata),
        .jpend                   (jpend),
        .jcmd                    (jcmd),
        .jaddr                   (jaddr),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

endmodule

// File: tb/tb_nios2_system_cpu_ocimem_arbiter.sv
// Scoreboard bench for the OCI debug-RAM arbiter with a behavioural RAM.
module tb_nios2_system_cpu_ocimem_arbiter;

    logic        clk;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;

    nios2_system_cpu_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_be                  (ram_be),
        .ram_we                  (ram_we),
        .ram_re                  (ram_re),
        .ram_rdata               (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM, preloaded with C0DE0000 | address.
    logic [31:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    always @(posedge clk) begin
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr][b*8 +: 8] = ram_wdata[b*8 +: 8];
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t jexp[$];
    exp_t cexp[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic prev_rdy = 1'b0;

    localparam int JA = 0;
    localparam int JB = 1;
    localparam int JN = 2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd, input logic clr);
        logic [37:0] j;
        j        = '0;
        j[25:18] = a;
        j[35]    = rd;
        j[36]    = clr;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] j;
        j       = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jpulse(input int kind, input logic [37:0] val);
        jdo = val;
        case (kind)
            JA:      take_action_ocimem_a = 1'b1;
            JB:      take_action_ocimem_b = 1'b1;
            default: take_no_action_ocimem_a = 1'b1;
        endcase
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!monitor_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!monitor_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL monitor_ready_timeout: got 0 required 1");
        end
        tick();
    endtask

    task automatic wait_cpu();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (avs_waitrequest && n < 20);
        if (avs_waitrequest) begin
            n_vec++;
            n_miss++;
            $display("FAIL cpu_waitrequest_timeout: got 1 required 0");
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        cexp.push_back('{1'b0, 32'h0});
        wait_cpu();
        check("cpu_wr_be", 64'(ram_be), 64'(be));
        tick();
        avs_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [31:0] exp);
        avs_address = a;
        avs_read    = 1'b1;
        cexp.push_back('{1'b1, exp});
        wait_cpu();
        tick();
        avs_read = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard on JTAG completion and on CPU handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_rdy = 1'b0;
            end else begin
                if (monitor_ready && !prev_rdy) begin
                    if (jexp.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL jtag_unexpected_completion: got 1 required 0");
                    end else begin
                        e = jexp.pop_front();
                        if (e.chk) check("jtag_mondreg", 64'(MonDReg), 64'(e.data));
                    end
                end
                prev_rdy = monitor_ready;
                if ((avs_read || avs_write) && !avs_waitrequest) begin
                    if (cexp.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL cpu_unexpected_handshake: got 1 required 0");
                    end else begin
                        e = cexp.pop_front();
                        check("cpu_op_is_read", 64'(avs_read), 64'(e.chk));
                        if (e.chk) check("cpu_readdata", 64'(avs_readdata), 64'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avs_address             = '0;
        avs_read                = 1'b0;
        avs_write               = 1'b0;
        avs_writedata           = '0;
        avs_byteenable          = 4'hF;
        reset                   = 1'b1;
        tick();
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_mondreg", 64'(MonDReg), 64'h0);
        check("rst_ready", 64'(monitor_ready), 64'h0);
        check("rst_error", 64'(monitor_error), 64'h0);
        check("rst_ram_we", 64'(ram_we), 64'h0);
        check("rst_ram_re", 64'(ram_re), 64'h0);
        check("rst_waitrequest", 64'(avs_waitrequest), 64'h0);
        tick();

        // Write then readback at 0x10; jaddr lands on 0x11
        jpulse(JA, mk_a(8'h10, 1'b0, 1'b0));
        jpulse(JB, mk_b(32'hDEADBEEF));
        jexp.push_back('{1'b0, 32'h0});
        @(negedge clk);
        check("jwr_ram_we", 64'(ram_we), 64'h1);
        check("jwr_ram_addr", 64'(ram_addr), 64'h10);
        check("jwr_ram_be", 64'(ram_be), 64'hF);
        check("jwr_ram_wdata", 64'(ram_wdata), 64'hDEADBEEF);
        wait_ready();
        jpulse(JA, mk_a(8'h10, 1'b1, 1'b0));
        jexp.push_back('{1'b1, 32'hDEADBEEF});
        @(negedge clk);
        check("jrd_ram_re", 64'(ram_re), 64'h1);
        wait_ready();
        jpulse(JN, '0);
        jexp.push_back('{1'b1, 32'hC0DE0011});
        wait_ready();

        // Streaming read across the address wrap
        jpulse(JA, mk_a(8'hFF, 1'b0, 1'b0));
        jpulse(JN, '0);
        jexp.push_back('{1'b1, 32'hC0DE00FF});
        wait_ready();
        jpulse(JN, '0);
        jexp.push_back('{1'b1, 32'hC0DE0000});
        wait_ready();

        // Dropped command during a CPU read (jaddr is now 1)
        avs_address          = 8'h20;
        avs_read             = 1'b1;
        jdo                  = mk_b(32'h11111111);
        take_action_ocimem_b = 1'b1;
        cexp.push_back('{1'b1, 32'hC0DE0020});
        jexp.push_back('{1'b0, 32'h0});
        @(negedge clk);
        check("cpu_rd_wait", 64'(avs_waitrequest), 64'h1);
        check("cpu_rd_ram_addr", 64'(ram_addr), 64'h20);
        tick();
        jdo = mk_b(32'h22222222);
        tick();
        take_action_ocimem_b = 1'b0;
        avs_read             = 1'b0;
        @(negedge clk);
        check("drop_error_set", 64'(monitor_error), 64'h1);
        check("drop_first_we", 64'(ram_we), 64'h1);
        check("drop_first_addr", 64'(ram_addr), 64'h1);
        check("drop_first_wdata", 64'(ram_wdata), 64'h11111111);
        wait_ready();
        jpulse(JA, mk_a(8'h01, 1'b1, 1'b1));
        jexp.push_back('{1'b1, 32'h11111111});
        @(negedge clk);
        check("error_cleared", 64'(monitor_error), 64'h0);
        wait_ready();

        // Contention right after reset
        do_reset();
        jpulse(JB, mk_b(32'h33333333));
        jexp.push_back('{1'b0, 32'h0});
        avs_address    = 8'h30;
        avs_writedata  = 32'hAAAAAAAA;
        avs_byteenable = 4'hF;
        avs_write      = 1'b1;
        cexp.push_back('{1'b0, 32'h0});
`ifdef OCIMEM_ROUND_ROBIN_EN
        @(negedge clk);
        check("rr_cpu_first_wait", 64'(avs_waitrequest), 64'h0);
        check("rr_cpu_first_addr", 64'(ram_addr), 64'h30);
        tick();
        avs_address   = 8'h31;
        avs_writedata = 32'hBBBBBBBB;
        cexp.push_back('{1'b0, 32'h0});
        @(negedge clk);
        check("rr_jtag_second_wait", 64'(avs_waitrequest), 64'h1);
        check("rr_jtag_second_addr", 64'(ram_addr), 64'h0);
        check("rr_jtag_second_we", 64'(ram_we), 64'h1);
        tick();
        @(negedge clk);
        check("rr_cpu_third_wait", 64'(avs_waitrequest), 64'h0);
        check("rr_cpu_third_addr", 64'(ram_addr), 64'h31);
`else
        @(negedge clk);
        check("fp_jtag_first_wait", 64'(avs_waitrequest), 64'h1);
        check("fp_jtag_first_addr", 64'(ram_addr), 64'h0);
        check("fp_jtag_first_wdata", 64'(ram_wdata), 64'h33333333);
        tick();
        @(negedge clk);
        check("fp_cpu_second_wait", 64'(avs_waitrequest), 64'h0);
        check("fp_cpu_second_addr", 64'(ram_addr), 64'h30);
`endif
        tick();
        avs_write = 1'b0;
        wait_ready();

        // Byte-enable write, then read back merged and contended words
        cpu_write(8'h40, 32'h12345678, 4'b0011);
        cpu_read(8'h40, 32'hC0DE5678);
        cpu_read(8'h00, 32'h33333333);
        cpu_read(8'h30, 32'hAAAAAAAA);
`ifdef OCIMEM_ROUND_ROBIN_EN
        cpu_read(8'h31, 32'hBBBBBBBB);
`endif

        // Reset asserted while a JTAG read sits in J_RD
        jpulse(JA, mk_a(8'h00, 1'b1, 1'b0));
        jexp.push_back('{1'b1, 32'h33333333});
        wait_ready();
        jpulse(JN, '0);
        @(negedge clk);
        check("abort_ram_re", 64'(ram_re), 64'h1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("abort_mondreg", 64'(MonDReg), 64'h0);
        check("abort_ready", 64'(monitor_ready), 64'h0);
        check("abort_ram_re_after", 64'(ram_re), 64'h0);
        tick();
        tick();

        check("jtag_queue_drained", 64'(jexp.size()), 64'h0);
        check("cpu_queue_drained", 64'(cexp.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
